// File: rtl/syndrome_decoder_pipe_pkg.sv
// Shared definitions for the pipelined syndrome decoder: legacy (9,3) code
// constants and the parity-check column helpers used at elaboration time.
package syndrome_decoder_pipe_pkg;

    // Widest P matrix / syndrome the helper functions can describe.
    localparam int MAX_PM_W = 1024;
    localparam int MAX_R_W  = 64;

    // Legacy (9,3) code: data bit i feeds parity bit j when bit i*6+j is set.
    localparam int              LEGACY_N        = 9;
    localparam int              LEGACY_K        = 3;
    localparam logic [17:0]     LEGACY_P_MATRIX = 18'h1D6AE;

    // Column c of H = [P^T | I]: a P row for data columns, one-hot for parity columns.
    function automatic logic [MAX_R_W-1:0] h_column(
        input logic [MAX_PM_W-1:0] pm,
        input int                  n,
        input int                  k,
        input int                  c
    );
        logic [MAX_R_W-1:0] col;
        col = {MAX_R_W{1'b0}};
        if (c < k) begin
            for (int j = 0; j < n - k; j++) begin
                col[j] = pm[c * (n - k) + j];
            end
        end else begin
            col[c - k] = 1'b1;
        end
        return col;
    endfunction

    // True when every H column is non-zero and no two columns are equal,
    // i.e. every single-bit error has a unique, non-zero syndrome.
    function automatic bit h_columns_distinct(
        input logic [MAX_PM_W-1:0] pm,
        input int                  n,
        input int                  k
    );
        bit ok;
        ok = 1'b1;
        for (int a = 0; a < n; a++) begin
            if (h_column(pm, n, k, a) == {MAX_R_W{1'b0}}) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
            for (int b = a + 1; b < n; b++) begin
                if (h_column(pm, n, k, a) == h_column(pm, n, k, b)) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/syndrome_decoder_pipe_syndrome_calc.sv
// Combinational syndrome generator: s = H * cw over GF(2).
module syndrome_calc
    import syndrome_decoder_pipe_pkg::*;
#(
    parameter int                 N        = LEGACY_N,
    parameter int                 K        = LEGACY_K,
    parameter logic [K*(N-K)-1:0] P_MATRIX = LEGACY_P_MATRIX
) (
    input  logic [N-1:0]   cw,
    output logic [N-K-1:0] syn
);

    localparam int                    R      = N - K;
    localparam logic [MAX_PM_W-1:0]   PM_EXT = MAX_PM_W'(P_MATRIX);

    logic [R-1:0] col_s [N];

    for (genvar c = 0; c < N; c++) begin : g_col
        localparam logic [MAX_R_W-1:0] COL_W = h_column(PM_EXT, N, K, c);
        assign col_s[c] = COL_W[R-1:0];
    end

    // XOR together the H columns selected by the set codeword bits.
    always_comb begin
        syn = {R{1'b0}};
        for (int c = 0; c < N; c++) begin
            syn = syn ^ (col_s[c] & {R{cw[c]}});
        end
    end

endmodule

// File: rtl/syndrome_decoder_pipe.sv
// Two-stage syndrome decoder: S1 registers the word and its syndrome, S2
// matches the syndrome against H, corrects a single data error and keeps
// saturating corrected/uncorrectable counters.
module syndrome_decoder_pipe
    import syndrome_decoder_pipe_pkg::*;
#(
    parameter int                 N        = LEGACY_N,
    parameter int                 K        = LEGACY_K,
    parameter logic [K*(N-K)-1:0] P_MATRIX = LEGACY_P_MATRIX,
    parameter int                 CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_cw,
    input  logic             correct_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_data,
    output logic [N-K-1:0]   out_syndrome,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam int                  R       = N - K;
    localparam int                  IDX_W   = $clog2(N);
    localparam logic [MAX_PM_W-1:0] PM_EXT  = MAX_PM_W'(P_MATRIX);
    localparam bit                  H_OK    = h_columns_distinct(PM_EXT, N, K);
    localparam logic [CNT_W-1:0]    CNT_MAX = {CNT_W{1'b1}};

    if ((K < 1) || (K >= N)) begin : g_bad_k
        $error("syndrome_decoder_pipe: K must satisfy 1 <= K < N");
    end else if ((R > MAX_R_W) || (K * R > MAX_PM_W)) begin : g_too_wide
        $error("syndrome_decoder_pipe: code too wide for the H helpers");
    end else if (!H_OK) begin : g_bad_h
        $error("syndrome_decoder_pipe: H columns must be non-zero and distinct");
    end

    // Stage registers
    logic             ready_en_r;
    logic             s1_valid_r;
    logic [N-1:0]     s1_cw_r;
    logic             s1_ce_r;
    logic [R-1:0]     s1_syn_r;
    logic             out_valid_r;
    logic [K-1:0]     out_data_r;
    logic [R-1:0]     out_syn_r;
    logic             out_corr_r;
    logic             out_uncorr_r;
    logic [CNT_W-1:0] corr_cnt_r;
    logic [CNT_W-1:0] uncorr_cnt_r;

    // Combinational signals
    logic [R-1:0]     syn_s;
    logic             s2_load_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [R-1:0]     h_col_s [N];
    logic [N-1:0]     hit_s;
    logic             found_s;
    logic [IDX_W-1:0] idx_s;
    logic             zero_s;
    logic             corr_s;
    logic             uncorr_s;
    logic [K-1:0]     data_s;

    syndrome_calc #(
        .N        (N),
        .K        (K),
        .P_MATRIX (P_MATRIX)
    ) u_syndrome_calc (
        .cw  (in_cw),
        .syn (syn_s)
    );

    for (genvar c = 0; c < N; c++) begin : g_match
        localparam logic [MAX_R_W-1:0] COL_W = h_column(PM_EXT, N, K, c);
        assign h_col_s[c] = COL_W[R-1:0];
        assign hit_s[c]   = (s1_syn_r == h_col_s[c]);
    end

    // S2 may take a new word whenever the output slot is empty or being drained.
    assign s2_load_s  = ~out_valid_r | out_ready;
    assign in_ready   = ready_en_r & (~s1_valid_r | s2_load_s);
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;

    // Lowest matching H column wins when resolving the error position.
    always_comb begin
        idx_s = {IDX_W{1'b0}};
        for (int c = N - 1; c >= 0; c--) begin
            idx_s = hit_s[c] ? IDX_W'(c) : idx_s;
        end
        found_s = |hit_s;
    end

    // Classify the S1 word and flip the erroneous data bit when allowed.
    always_comb begin
        zero_s   = (s1_syn_r == {R{1'b0}});
        corr_s   = ~zero_s & found_s;
        uncorr_s = ~zero_s & ~found_s;
        data_s   = s1_cw_r[K-1:0];
        for (int i = 0; i < K; i++) begin
            data_s[i] = data_s[i] ^ (corr_s & s1_ce_r & (idx_s == IDX_W'(i)));
        end
    end

    // Hold in_ready low through reset and enable it from the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // S1: capture the accepted word with its syndrome; empty when it moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_cw_r    <= {N{1'b0}};
            s1_ce_r    <= 1'b0;
            s1_syn_r   <= {R{1'b0}};
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            s1_cw_r    <= in_cw;
            s1_ce_r    <= correct_en;
            s1_syn_r   <= syn_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2: output register, frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {K{1'b0}};
            out_syn_r    <= {R{1'b0}};
            out_corr_r   <= 1'b0;
            out_uncorr_r <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r   <= data_s;
                out_syn_r    <= s1_syn_r;
                out_corr_r   <= corr_s;
                out_uncorr_r <= uncorr_s;
            end else begin
                out_data_r   <= out_data_r;
                out_syn_r    <= out_syn_r;
                out_corr_r   <= out_corr_r;
                out_uncorr_r <= out_uncorr_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating delivery counters; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= {CNT_W{1'b0}};
            uncorr_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            corr_cnt_r   <= {CNT_W{1'b0}};
            uncorr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_fire_s && out_corr_r && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                corr_cnt_r <= corr_cnt_r;
            end
            if (out_fire_s && out_uncorr_r && (uncorr_cnt_r != CNT_MAX)) begin
                uncorr_cnt_r <= uncorr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                uncorr_cnt_r <= uncorr_cnt_r;
            end
        end
    end

    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_syndrome = out_syn_r;
    assign out_corr     = out_corr_r;
    assign out_uncorr   = out_uncorr_r;
    assign corr_cnt     = corr_cnt_r;
    assign uncorr_cnt   = uncorr_cnt_r;

endmodule

// File: tb/tb_syndrome_decoder_pipe.sv
// Bench for syndrome_decoder_pipe on the legacy (9,3) code with narrow
// counters so saturation is reachable quickly.
module tb_syndrome_decoder_pipe;

    localparam int          N     = 9;
    localparam int          K     = 3;
    localparam int          R     = 6;
    localparam int          CNT_W = 4;
    localparam int          CMAX  = 15;
    localparam logic [17:0] P_MAT = 18'h1D6AE;

    typedef struct packed {
        logic [2:0] data;
        logic [5:0] syn;
        logic       corr;
        logic       uncorr;
    } res_t;

    typedef struct {
        logic [8:0] cw;
        logic       ce;
        logic [2:0] data;
        logic [5:0] syn;
        logic       corr;
        logic       uncorr;
        int         ccnt;
        int         ucnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_cw = 9'd0;
    logic             correct_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [K-1:0]     out_data;
    logic [R-1:0]     out_syndrome;
    logic             out_corr;
    logic             out_uncorr;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_corr = 0;
    int   m_uncorr = 0;
    res_t sb[$];
    bit   prev_stall = 1'b0;
    res_t prev_out;
    res_t last_act;
    bit   in_fire_l;
    bit   out_fire_l;
    bit   last_ov;
    int   blocked_cnt = 0;
    vec_t tbl[10];

    syndrome_decoder_pipe #(
        .N        (N),
        .K        (K),
        .P_MATRIX (P_MAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cw        (in_cw),
        .correct_en   (correct_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_corr     (out_corr),
        .out_uncorr   (out_uncorr),
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Parity bits a valid codeword carries for data d.
    function automatic logic [5:0] encode(input logic [2:0] d);
        logic [5:0]  p;
        logic [17:0] pm;
        p  = 6'd0;
        pm = P_MAT;
        for (int i = 0; i < 3; i++) begin
            if (d[i]) p = p ^ pm[i*6 +: 6];
        end
        return p;
    endfunction

    // Reference: syndrome = received parity vs re-encoded parity; a single
    // error at position c exists when flipping bit c yields a codeword.
    function automatic res_t ref_model(input logic [8:0] cw, input logic ce);
        res_t       r;
        logic [8:0] t;
        r.syn    = cw[8:3] ^ encode(cw[2:0]);
        r.data   = cw[2:0];
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        if (r.syn != 6'd0) begin
            r.uncorr = 1'b1;
            for (int c = 8; c >= 0; c--) begin
                t = cw ^ (9'd1 << c);
                if (t[8:3] == encode(t[2:0])) begin
                    r.corr   = 1'b1;
                    r.uncorr = 1'b0;
                    r.data   = ce ? t[2:0] : cw[2:0];
                end
            end
        end
        return r;
    endfunction

    // One clock of stimulus plus all per-cycle protocol and model checks.
    task automatic cycle(input logic iv, input logic [8:0] cw, input logic ce,
                         input logic ordy, input logic clr);
        bit   s1_full;
        bit   exp_rdy;
        bit   have_e;
        res_t act;
        res_t e;
        @(negedge clk);
        in_valid   = iv;
        in_cw      = cw;
        correct_en = ce;
        out_ready  = ordy;
        cnt_clr    = clr;
        #1;
        act = '{data: out_data, syn: out_syndrome, corr: out_corr, uncorr: out_uncorr};
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_fields", 32'(act), 32'(prev_out));
        end
        s1_full = (sb.size() == 2) || ((sb.size() == 1) && !out_valid);
        exp_rdy = !s1_full || !out_valid || out_ready;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (!in_ready) blocked_cnt++;
        if (sb.size() == 0) check("idle_out_valid", 32'(out_valid), 32'd0);
        check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
        check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
        in_fire_l  = in_valid && in_ready;
        out_fire_l = out_valid && out_ready;
        last_ov    = out_valid;
        last_act   = act;
        have_e     = 1'b0;
        e          = '0;
        if (out_fire_l) begin
            check("out_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e      = sb.pop_front();
                have_e = 1'b1;
                check("out_data", 32'(act.data), 32'(e.data));
                check("out_syndrome", 32'(act.syn), 32'(e.syn));
                check("out_corr", 32'(act.corr), 32'(e.corr));
                check("out_uncorr", 32'(act.uncorr), 32'(e.uncorr));
            end
        end
        if (clr) begin
            m_corr   = 0;
            m_uncorr = 0;
        end else if (have_e) begin
            if (e.corr && (m_corr < CMAX)) m_corr++;
            if (e.uncorr && (m_uncorr < CMAX)) m_uncorr++;
        end
        if (in_fire_l) sb.push_back(ref_model(cw, ce));
        prev_stall = out_valid && !out_ready;
        prev_out   = act;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() > 0) && (w < 30)) begin
            cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
            w++;
        end
        check("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   sent;
        int   w;
        int   lat;
        bit   got;

        //          cw       ce    data    syn    corr  unc   ccnt ucnt
        tbl[0] = '{9'h19D, 1'b1, 3'b101, 6'h00, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{9'h19F, 1'b1, 3'b101, 6'h1A, 1'b1, 1'b0, 1, 0};
        tbl[2] = '{9'h19F, 1'b0, 3'b111, 6'h1A, 1'b1, 1'b0, 2, 0};
        tbl[3] = '{9'h1DD, 1'b1, 3'b101, 6'h08, 1'b1, 1'b0, 3, 0};
        tbl[4] = '{9'h19E, 1'b1, 3'b110, 6'h34, 1'b0, 1'b1, 3, 1};
        tbl[5] = '{9'h199, 1'b1, 3'b101, 6'h1D, 1'b1, 1'b0, 4, 1};
        tbl[6] = '{9'h09D, 1'b1, 3'b101, 6'h20, 1'b1, 1'b0, 5, 1};
        tbl[7] = '{9'h19C, 1'b0, 3'b100, 6'h2E, 1'b1, 1'b0, 6, 1};
        tbl[8] = '{9'h000, 1'b1, 3'b000, 6'h00, 1'b0, 1'b0, 6, 1};
        tbl[9] = '{9'h099, 1'b1, 3'b001, 6'h3D, 1'b0, 1'b1, 6, 2};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fields", 32'({out_data, out_syndrome, out_corr, out_uncorr}), 32'd0);
        check("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one word at a time
        for (int v = 0; v < 10; v++) begin
            w = 0;
            do begin
                cycle(1'b1, tbl[v].cw, tbl[v].ce, 1'b1, 1'b0);
                w++;
            end while (!in_fire_l && (w < 20));
            check("tbl_accept", 32'(in_fire_l), 32'd1);
            lat = 0;
            got = 1'b0;
            while (!got && (lat < 20)) begin
                cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
                lat++;
                got = out_fire_l;
            end
            check("tbl_latency", 32'(lat), 32'd2);
            check("tbl_data", 32'(last_act.data), 32'(tbl[v].data));
            check("tbl_syndrome", 32'(last_act.syn), 32'(tbl[v].syn));
            check("tbl_corr", 32'(last_act.corr), 32'(tbl[v].corr));
            check("tbl_uncorr", 32'(last_act.uncorr), 32'(tbl[v].uncorr));
            cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
            check("tbl_corr_cnt", 32'(corr_cnt), 32'(tbl[v].ccnt));
            check("tbl_uncorr_cnt", 32'(uncorr_cnt), 32'(tbl[v].ucnt));
        end

        // Back-to-back stream of 10 words with consumer stalled for cycles 3-5
        sent        = 0;
        blocked_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(sent < 10, 9'($urandom), 1'($urandom), !((k >= 3) && (k <= 5)), 1'b0);
            if (in_fire_l) sent++;
        end
        check("stream_sent", 32'(sent), 32'd10);
        check("stream_drained", 32'(sb.size()), 32'd0);
        check("stream_backpressure", 32'(blocked_cnt > 0), 32'd1);

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, 9'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end
        drain();

        // Saturation: more corrected words than the counter can hold
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 9'h19F, 1'b1, 1'b1, 1'b0);
        end
        drain();
        cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        check("sat_corr_cnt", 32'(corr_cnt), 32'(CMAX));

        // Clear coinciding with a corrected-word handshake yields zero
        w = 0;
        do begin
            cycle(1'b1, 9'h19F, 1'b1, 1'b0, 1'b0);
            w++;
        end while (!in_fire_l && (w < 20));
        w = 0;
        do begin
            cycle(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
            w++;
        end while (!last_ov && (w < 20));
        check("clr_wait_valid", 32'(last_ov), 32'd1);
        cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b1);
        check("clr_handshake", 32'(out_fire_l), 32'd1);
        cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        check("clr_corr_cnt", 32'(corr_cnt), 32'd0);

        // Reset in the middle of a stream discards everything in flight
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 9'h19E, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        m_corr     = 0;
        m_uncorr   = 0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        end
        cycle(1'b1, 9'h19F, 1'b0, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
